lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the DPI-C memory model.
- Accepts one load or store request at a time from the MEM stage over a valid/ready handshake, checks alignment, and drives the model's rd/we ports for exactly one cycle.
- Size/sign-extends load data and returns a registered response over a second valid/ready handshake.

Parameters:
- XLEN, 64, address/data width
- ERR_RDATA, 64'h0, resp_rdata value returned on a misaligned access

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, low-aligned
- req_size  in  2  0=byte, 1=half, 2=word, 3=double
- req_signed  in  1  sign-extend load result
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores
- resp_err  out  1  misaligned access, no memory effect
- mem_rd_en  out  1  to memory rd_en
- mem_rd_addr  out  64  to memory rd_addr
- mem_rd_data  in  64  from memory rd_data, combinational, 8 bytes starting at rd_addr
- mem_we_en  out  1  to memory we_en
- mem_we_addr  out  64  to memory we_addr
- mem_we_data  out  64  to memory we_data
- mem_we_mask  out  8  to memory we_mask: 8'h01, 8'h03, 8'h0F or 8'hFF only

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers cleared. Reset asserted mid-operation aborts at once; mem_we_en drops asynchronously and no partial store is issued afterwards.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Misaligned (addr & (size_bytes-1) != 0): go to RESP with resp_err=1, resp_rdata=ERR_RDATA. No memory port asserted.
  - Otherwise: go to ACCESS.
- ACCESS (exactly 1 cycle): mem_* outputs are registered and valid during this cycle only.
  - Load: mem_rd_en=1, mem_rd_addr=addr. mem_rd_data is sampled at the end of the cycle, taking bits [8*n-1:0] with n = 1 << size. Zero-extend, or sign-extend from bit 8*n-1 when req_signed. req_signed is ignored for size 3.
  - Store: mem_we_en=1, mem_we_addr=addr, mem_we_data=wdata unshifted, mem_we_mask=(1<<n)-1.
  - Then go to RESP.
- RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready. On resp_valid && resp_ready go to IDLE. req_ready=0 (base build).
- Outside ACCESS: mem_rd_en=mem_we_en=0 and all mem address/data/mask outputs are 0.
- Latency: request accepted at cycle t, memory access at t+1, resp_valid at t+2. Misaligned request: resp_valid at t+1.
- Throughput: base build completes one request per 3 cycles.
- No request is ever dropped; req_* inputs are don't-care while req_ready=0.

Optional Feature:
- Macro: LSU_PIPE_EN
- Defined: in RESP, req_ready = resp_ready. A handshake in the same cycle as the response handshake latches the new request and goes directly to ACCESS (or RESP if misaligned), giving 2-cycle throughput.
- Undefined: base behaviour (req_ready only in IDLE).

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B/SZ_H/SZ_W/SZ_D)
  - state enum (IDLE/ACCESS/RESP)
  - mask constants 8'h01/03/0F/FF
  - function size_to_bytes
- Sub-module lsu_load_ext: combinational size/sign extension of a 64-bit raw word by size and signed flag; instantiated once in the ACCESS capture path.

Test Plan:
- Store D, addr 0x80000008, wdata 0x1122334455667788 → one cycle of mem_we_en=1, mask 8'hFF, data unchanged; resp_valid 2 cycles after accept, resp_err=0.
- Load B signed, addr 0x80000003, mem_rd_data 0x...0080 → resp_rdata 0xFFFFFFFFFFFFFF80. Same load unsigned → 0x80.
- Store H, addr 0x80000001 → resp_err=1 one cycle after accept, mem_we_en never asserted, resp_rdata=ERR_RDATA.
- Load W with resp_ready held 0 for 5 cycles → resp_valid and resp_rdata stable throughout, req_ready=0; completes on the first resp_ready=1 cycle.
- reset_n pulled low during ACCESS of a store → mem_we_en falls immediately; after release all outputs are 0, state IDLE, req_ready=1.
- LSU_PIPE_EN defined, back-to-back loads with resp_ready=1 → accepts every 2 cycles, responses in order; undefined → every 3 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store controller:
//               access-size and FSM state enums, store byte-mask constants,
//               and size decoding functions.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Number of bytes covered by an access of the given size.
    function automatic logic [3:0] size_to_bytes(input lsu_size_e sz);
        logic [3:0] bytes;
        case (sz)
            SZ_B:    bytes = 4'd1;
            SZ_H:    bytes = 4'd2;
            SZ_W:    bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

    // Store byte-enable mask for the given size, always low-aligned.
    function automatic logic [7:0] size_to_mask(input lsu_size_e sz);
        logic [7:0] mask;
        case (sz)
            SZ_B:    mask = MASK_B;
            SZ_H:    mask = MASK_H;
            SZ_W:    mask = MASK_W;
            default: mask = MASK_D;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational load-data extension. Takes the low 1/2/4/8
//               bytes of a raw memory word and zero- or sign-extends them to
//               the full data width. The signed flag has no effect on
//               double-word loads.
// Revision    : 1.0 - initial release
// Ports       : raw       in  XLEN  raw memory word (data starts at bit 0)
//               size      in  2     access size (lsu_size_e)
//               is_signed in  1     sign-extend from the top loaded bit
//               ext       out XLEN  extended result
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  lsu_size_e       size,
    input  logic            is_signed,
    output logic [XLEN-1:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SZ_B:    ext = {{(XLEN-8){is_signed & raw[7]}},   raw[7:0]};
            SZ_H:    ext = {{(XLEN-16){is_signed & raw[15]}}, raw[15:0]};
            SZ_W:    ext = {{(XLEN-32){is_signed & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Load/store controller in front of the memory model. Accepts
//               one request at a time, checks alignment, drives the memory
//               read or write port for exactly one cycle and returns a
//               registered, size-extended response.
// Revision    : 1.0 - initial release
// Config      : LSU_PIPE_EN - when defined, a new request may be accepted in
//               the same cycle the response is consumed (2-cycle throughput);
//               otherwise requests are only taken in IDLE (3-cycle).
// Ports       : clock, reset_n (async active-low)
//               req_valid/req_ready/req_we/req_addr/req_wdata/req_size/
//               req_signed            request channel
//               resp_valid/resp_ready/resp_rdata/resp_err  response channel
//               mem_rd_en/mem_rd_addr/mem_rd_data          memory read port
//               mem_we_en/mem_we_addr/mem_we_data/mem_we_mask  write port
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int               XLEN      = 64,
    parameter logic [XLEN-1:0]  ERR_RDATA = '0
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_signed,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,

    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_rd_addr,
    input  logic [XLEN-1:0] mem_rd_data,
    output logic            mem_we_en,
    output logic [XLEN-1:0] mem_we_addr,
    output logic [XLEN-1:0] mem_we_data,
    output logic [7:0]      mem_we_mask
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    lsu_size_e       size_q, size_d;
    logic            signed_q, signed_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic            mem_rd_en_q, mem_rd_en_d;
    logic [XLEN-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic            mem_we_en_q, mem_we_en_d;
    logic [XLEN-1:0] mem_we_addr_q, mem_we_addr_d;
    logic [XLEN-1:0] mem_we_data_q, mem_we_data_d;
    logic [7:0]      mem_we_mask_q, mem_we_mask_d;

    lsu_size_e       req_size_e;
    logic [XLEN-1:0] align_mask;
    logic            misaligned;
    logic [XLEN-1:0] load_ext;

    assign req_size_e = lsu_size_e'(req_size);
    // Low address bits that must be zero: size_bytes - 1.
    assign align_mask = {{(XLEN-4){1'b0}}, size_to_bytes(req_size_e)} - XLEN'(1);
    assign misaligned = |(req_addr & align_mask);

    // Extension acts on the latched size/sign while the read port is live.
    lsu_load_ext #(
        .XLEN      (XLEN)
    ) u_load_ext (
        .raw       (mem_rd_data),
        .size      (size_q),
        .is_signed (signed_q),
        .ext       (load_ext)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        signed_d      = signed_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        // Memory port registers are only non-zero for the ACCESS cycle, so
        // they default to zero and are loaded only on entry to ACCESS.
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = '0;
        mem_we_en_d   = 1'b0;
        mem_we_addr_d = '0;
        mem_we_data_d = '0;
        mem_we_mask_d = '0;
        req_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            ACCESS: begin
                state_d      = RESP;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? '0 : load_ext;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
`ifdef LSU_PIPE_EN
                req_ready = resp_ready;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request acceptance overrides the RESP->IDLE transition when the
        // pipelined build takes a new request alongside the response.
        if (req_valid && req_ready) begin
            we_d     = req_we;
            size_d   = req_size_e;
            signed_d = req_signed;
            if (misaligned) begin
                state_d      = RESP;
                resp_err_d   = 1'b1;
                resp_rdata_d = ERR_RDATA;
            end else begin
                state_d = ACCESS;
                if (req_we) begin
                    mem_we_en_d   = 1'b1;
                    mem_we_addr_d = req_addr;
                    mem_we_data_d = req_wdata;
                    mem_we_mask_d = size_to_mask(req_size_e);
                end else begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = req_addr;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= SZ_B;
            signed_q      <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_we_en_q   <= 1'b0;
            mem_we_addr_q <= '0;
            mem_we_data_q <= '0;
            mem_we_mask_q <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_we_en_q   <= mem_we_en_d;
            mem_we_addr_q <= mem_we_addr_d;
            mem_we_data_q <= mem_we_data_d;
            mem_we_mask_q <= mem_we_mask_d;
        end
    end

    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_we_en   = mem_we_en_q;
    assign mem_we_addr = mem_we_addr_q;
    assign mem_we_data = mem_we_data_q;
    assign mem_we_mask = mem_we_mask_q;

endmodule
`default_nettype wire
